hwgen_hdr_builder: RTL

Converts the stream of normalised pcap record headers (64-bit nanosecond timestamp, incl_len, orig_len) into hwgen transmit headers (magic, orig_len, inter-frame gap in clock cycles). It sits directly downstream of the pcap record parser and upstream of the hardware packet generator. It computes each packet's gap from consecutive timestamps, converts the gap to 156.25 MHz cycles, and subtracts the previous frame's wire occupancy.

---
 rtl/hwgen_hdr_builder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hwgen_hdr_builder.sv
// hwgen_hdr_builder
//   Turns normalised pcap record headers (ns timestamp, incl_len, orig_len)
//   into hwgen transmit headers (magic, clamped orig_len, inter-frame gap in
//   156.25 MHz cycles). The gap is the timestamp delta converted to cycles
//   minus the wire occupancy of the previous frame.
//
//   Two-stage pipeline:
//     S1: timestamp delta, occupancy of the previous frame, clamped length
//     S2: final ifg, drives the out_* header until downstream accepts it
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   restart               next accepted header starts a new capture (ifg = 0)
//   hdr_ts/incl_len/orig_len, hdr_valid, hdr_ready   input header stream
//   out_magic/orig_len/ifg, out_valid, out_ready     output header stream
//   ts_backwards_cnt      saturating count of timestamps below predecessor
//   len_clamp_cnt         saturating count of clamped orig_len values
module hwgen_hdr_builder #(
  parameter int          BYTES_PER_CYCLE = 8,
  parameter logic [15:0] MAGIC           = 16'h6969,
  parameter int          IFG_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [63:0]      hdr_ts,
  input  logic [31:0]      hdr_incl_len,
  input  logic [31:0]      hdr_orig_len,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  output logic [16:0]      out_magic,
  output logic [16:0]      out_orig_len,
  output logic [IFG_W-1:0] out_ifg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      ts_backwards_cnt,
  output logic [15:0]      len_clamp_cnt
);

  localparam int          OCC_SHIFT = $clog2(BYTES_PER_CYCLE);
  localparam logic [16:0] LEN_MAX   = 17'h1FFFF;

  // Captured length is passed through the parser but has no use here.
  logic unused_incl_len;
  assign unused_incl_len = ^hdr_incl_len;

  logic        first_flag;
  logic [63:0] prev_ts;
  logic [31:0] prev_occ;

  logic        s1_valid;
  logic [63:0] s1_delta;
  logic [31:0] s1_occ;
  logic [16:0] s1_len;

  logic        s2_valid;
  logic        s2_load;
  logic        hdr_accept;

  assign s2_load    = !s2_valid || out_ready;
  assign hdr_ready  = !s1_valid || s2_load;
  assign hdr_accept = hdr_valid && hdr_ready;
  assign out_valid  = s2_valid;

  // Input-side calculations
  logic        is_first;
  logic        ts_backwards;
  logic        len_clamped;
  logic [16:0] len_sat;
  logic [63:0] delta_ns;
  logic [31:0] occ_new;

  always_comb begin
    is_first     = first_flag || restart;
    ts_backwards = !is_first && (hdr_ts < prev_ts);
    delta_ns     = (is_first || ts_backwards) ? 64'd0 : (hdr_ts - prev_ts);
    len_clamped  = |hdr_orig_len[31:17];
    len_sat      = len_clamped ? LEN_MAX : hdr_orig_len[16:0];
    occ_new      = 32'((18'(len_sat) + 18'(BYTES_PER_CYCLE - 1)) >> OCC_SHIFT);
  end

  // Gap conversion: delta/6.4 == (delta*5)>>5, kept in 67 bits so the
  // multiply never overflows for any 64-bit delta.
  logic [66:0]      cyc_prod;
  logic [66:0]      cycles;
  logic [66:0]      cyc_diff;
  logic [IFG_W-1:0] ifg_calc;

  always_comb begin
    cyc_prod = 67'(s1_delta) * 67'd5;
    cycles   = cyc_prod >> 5;
    cyc_diff = cycles - 67'(s1_occ);
    if (cycles < 67'(s1_occ)) begin
      ifg_calc = '0;
    end else if (|cyc_diff[66:IFG_W]) begin
      ifg_calc = '1;
    end else begin
      ifg_calc = cyc_diff[IFG_W-1:0];
    end
  end

  // Capture state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_flag       <= 1'b1;
      prev_ts          <= '0;
      prev_occ         <= '0;
      ts_backwards_cnt <= '0;
      len_clamp_cnt    <= '0;
    end else begin
      if (hdr_accept) begin
        first_flag <= 1'b0;
        prev_ts    <= hdr_ts;
        prev_occ   <= occ_new;
        if (ts_backwards && (ts_backwards_cnt != 16'hFFFF)) begin
          ts_backwards_cnt <= ts_backwards_cnt + 16'd1;
        end
        if (len_clamped && (len_clamp_cnt != 16'hFFFF)) begin
          len_clamp_cnt <= len_clamp_cnt + 16'd1;
        end
      end else if (restart) begin
        first_flag <= 1'b1;
      end
    end
  end

  // Stage 1: the occupancy carried is the previous frame's, sampled before
  // this accept overwrites prev_occ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_delta <= '0;
      s1_occ   <= '0;
      s1_len   <= '0;
    end else if (hdr_ready) begin
      s1_valid <= hdr_accept;
      if (hdr_accept) begin
        s1_delta <= delta_ns;
        s1_occ   <= prev_occ;
        s1_len   <= len_sat;
      end
    end
  end

  // Stage 2 / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      out_magic    <= '0;
      out_orig_len <= '0;
      out_ifg      <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_magic    <= {1'b0, MAGIC};
        out_orig_len <= s1_len;
        out_ifg      <= ifg_calc;
      end
    end
  end

endmodule
